// File: rtl/mem_stage_pkg.sv
// Shared widths and load-operation encodings for the memory stage of the core.
// Bit 2 of a load opcode selects zero-extension; bits 1:0 select byte/half/word.
package mem_stage_pkg;

  localparam int ES_TO_MS_BUS_WD = 75;
  localparam int MS_TO_WS_BUS_WD = 70;
  localparam int MS_TO_DS_BUS_WD = 38;

  localparam logic [2:0] LD_W  = 3'b000;
  localparam logic [2:0] LD_B  = 3'b001;
  localparam logic [2:0] LD_H  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b101;
  localparam logic [2:0] LD_HU = 3'b110;

endpackage

// File: rtl/mem_load_align.sv
// Selects and extends the byte/half/word addressed by a load from the raw SRAM word.
// Unrecognised opcodes fall back to a full-word load; no misalignment checking.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] ld_data,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  load_op,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = ld_data[7:0];
    case (addr_lo)
      2'd0: byte_sel = ld_data[7:0];
      2'd1: byte_sel = ld_data[15:8];
      2'd2: byte_sel = ld_data[23:16];
      2'd3: byte_sel = ld_data[31:24];
      default: byte_sel = ld_data[7:0];
    endcase
  end

  // Halfword selection uses only addr_lo[1]; the low address bit is ignored.
  assign half_sel = addr_lo[1] ? ld_data[31:16] : ld_data[15:0];

  always_comb begin
    result = ld_data;
    case (load_op)
      LD_B:    result = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   result = {24'd0, byte_sel};
      LD_H:    result = {{16{half_sel[15]}}, half_sel};
      LD_HU:   result = {16'd0, half_sel};
      default: result = ld_data;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: accepts from exe, captures load data, aligns it,
// and forwards the result to wb and (combinationally) to decode for bypass.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic [31:0]                data_sram_rdata,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus
);

  // Handshake: a stage holds an instruction while ms_valid; it may accept a new
  // one when empty or when its current occupant leaves to wb this same cycle.
  logic                       ms_valid;
  logic                       ms_ready_go;
  logic                       first_cyc;
  logic [31:0]                rdata_buf;
  logic [ES_TO_MS_BUS_WD-1:0] bus_r;

  logic [2:0]  load_op;
  logic        no_dest;
  logic        res_from_mem;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] alu_result;
  logic [31:0] pc;

  logic [31:0] ld_data;
  logic [31:0] load_result;
  logic [31:0] final_result;
  logic [4:0]  dest_masked;
  logic        fwd_we;

  assign {load_op, no_dest, res_from_mem, gr_we, dest, alu_result, pc} = bus_r;

  assign ms_ready_go    = 1'b1;
  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ms_valid  <= 1'b0;
      first_cyc <= 1'b0;
      rdata_buf <= 32'd0;
    end else begin
      if (ms_allowin) begin
        ms_valid <= es_to_ms_valid;
      end
      first_cyc <= es_to_ms_valid && ms_allowin;
      if (first_cyc) begin
        rdata_buf <= data_sram_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (es_to_ms_valid && ms_allowin) begin
      bus_r <= es_to_ms_bus;
    end
  end

  // The SRAM keeps reading for younger instructions while we stall, so the live
  // rdata is only ours in the first resident cycle; afterwards use the copy.
  assign ld_data = first_cyc ? data_sram_rdata : rdata_buf;

  mem_load_align u_align (
    .ld_data (ld_data),
    .addr_lo (alu_result[1:0]),
    .load_op (load_op),
    .result  (load_result)
  );

  assign final_result = res_from_mem ? load_result : alu_result;
  assign dest_masked  = ms_valid ? dest : 5'd0;
  assign fwd_we       = ms_valid && gr_we && !no_dest && (dest != 5'd0);

  assign ms_to_ws_bus = {gr_we, dest_masked, final_result, pc};
  assign ms_to_ds_bus = {fwd_we, dest_masked, final_result};

endmodule
